// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//
// Contents:
//   BCD_NIB_W   width of one BCD digit
//   BIN_W_DEF   default binary input width (14 bits, max 16383)
//   DIGITS_DEF  default number of displayed BCD digits
//   state_t     converter FSM states
//   add3_fix    double-dabble nibble correction (>=5 -> +3)
//
// Build option: BIN2BCD_SAT_EN (see bin2bcd_seq.sv).
package bin2bcd_seq_pkg;

  localparam int BCD_NIB_W  = 4;
  localparam int BIN_W_DEF  = 14;
  localparam int DIGITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [BCD_NIB_W-1:0] add3_fix(input logic [BCD_NIB_W-1:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Single-digit double-dabble correction: a nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
//
// Ports:
//   nib  input  BCD_NIB_W  digit before correction
//   fix  output BCD_NIB_W  digit after correction
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_NIB_W-1:0] nib,
  output logic [BCD_NIB_W-1:0] fix
);

  assign fix = add3_fix(nib);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble) with a
// start/busy/done handshake. The packed result, overflow flag and
// leading-zero mask are held stable between conversions and only change
// on the done pulse.
//
// Ports:
//   signal  input  1          system clock
//   rst_n   input  1          asynchronous active-low reset
//   start   input  1          conversion request, sampled only in IDLE
//   bin     input  BIN_W      binary value, captured on the accepted start
//   busy    output 1          conversion in progress
//   done    output 1          one-cycle pulse when bcd/ovf/blank update
//   bcd     output 4*DIGITS   packed BCD, units digit in [3:0]
//   ovf     output 1          captured value exceeded 10^DIGITS-1
//   blank   output DIGITS     leading-zero mask (1 = blank), [0] always 0
//
// Build option BIN2BCD_SAT_EN: on overflow, bcd saturates to all nines and
// blank is cleared. Without it, bcd holds the value modulo 10^DIGITS.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one correct-then-shift step per cycle, BIN_W steps total
// DONE  | publish result; done pulses on the following cycle
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                          signal,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_NIB_W*DIGITS-1:0]   bcd,
  output logic                          ovf,
  output logic [DIGITS-1:0]             blank
);

  // One spare digit above the displayed ones catches overflow.
  localparam int ACC_W = BCD_NIB_W * (DIGITS + 1);
  localparam int OUT_W = BCD_NIB_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_fix;
  logic [BIN_W-1:0]  bin_sh;
  logic [CNT_W-1:0]  cnt;
  logic              load, shift_en, publish;

  logic [OUT_W-1:0]  low_digits;
  logic              res_ovf;
  logic [DIGITS-1:0] lz_mask;
  logic [OUT_W-1:0]  bcd_nxt;
  logic [DIGITS-1:0] blank_nxt;

  genvar g;
  generate
    for (g = 0; g < DIGITS + 1; g++) begin : g_add3
      bcd_add3 u_add3 (
        .nib (acc[g*BCD_NIB_W +: BCD_NIB_W]),
        .fix (acc_fix[g*BCD_NIB_W +: BCD_NIB_W])
      );
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge signal or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs / datapath controls
  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    publish  = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE:    load = start;
      SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      DONE:    publish = 1'b1;
      default: ;
    endcase
  end

  // Shift datapath: correction and shift happen in the same cycle.
  always_ff @(posedge signal or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      bin_sh <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      bin_sh <= bin;
      cnt    <= '0;
    end else if (shift_en) begin
      {acc, bin_sh} <= {acc_fix, bin_sh} << 1;
      cnt           <= cnt + 1'b1;
    end
  end

  assign low_digits = acc[OUT_W-1:0];
  assign res_ovf    = |acc[ACC_W-1 -: BCD_NIB_W];

  // Leading-zero mask: a digit blanks only if it and everything above it is 0.
  always_comb begin
    logic zero_run;
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (low_digits[i*BCD_NIB_W +: BCD_NIB_W] == '0);
      lz_mask[i] = zero_run;
    end
  end

`ifdef BIN2BCD_SAT_EN
  always_comb begin
    bcd_nxt   = low_digits;
    blank_nxt = lz_mask;
    if (res_ovf) begin
      bcd_nxt   = {DIGITS{4'h9}};
      blank_nxt = '0;
    end
  end
`else
  always_comb begin
    bcd_nxt   = low_digits;
    blank_nxt = lz_mask;
  end
`endif

  // Published outputs: only touched in DONE, so the display never sees a
  // partially converted word.
  always_ff @(posedge signal or negedge rst_n) begin
    if (!rst_n) begin
      done  <= 1'b0;
      bcd   <= '0;
      ovf   <= 1'b0;
      blank <= BLANK_RST;
    end else begin
      done <= publish;
      if (publish) begin
        bcd   <= bcd_nxt;
        ovf   <= res_ovf;
        blank <= blank_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq with a result scoreboard.
module tb_bin2bcd_seq;

  logic        signal = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [13:0] bin    = '0;
  logic        busy, done, ovf;
  logic [15:0] bcd;
  logic [3:0]  blank;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
  } res_t;

  res_t q[$];
  int   tests = 0;
  int   fails = 0;

  bin2bcd_seq dut (
    .signal (signal),
    .rst_n  (rst_n),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd),
    .ovf    (ovf),
    .blank  (blank)
  );

  always #5 signal = ~signal;

  function automatic res_t model(input int v);
    res_t r;
    int   low;
    int   d[4];
    logic zr;
    r.ovf = (v > 9999);
    low   = v % 10000;
    for (int i = 0; i < 4; i++) begin
      d[i] = low % 10;
      low  = low / 10;
    end
    r.bcd   = {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0]};
    r.blank = 4'b0000;
    zr      = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      zr         = zr & (d[i] == 0);
      r.blank[i] = zr;
    end
`ifdef BIN2BCD_SAT_EN
    if (r.ovf) begin
      r.bcd   = 16'h9999;
      r.blank = 4'b0000;
    end
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive start for one cycle; the edge at the end of this task accepts it.
  task automatic start_conv(input int v);
    bin   = 14'(v);
    start = 1'b1;
    q.push_back(model(v));
    @(posedge signal); #1;
    start = 1'b0;
  endtask

  // Wait for done, checking latency, busy width and the scoreboard entry.
  // pulse_at > 0 injects an extra start (with a different bin) at that cycle.
  task automatic wait_done(input string tag, input int pulse_at);
    int   k = 0;
    int   busy_cnt = 0;
    res_t e;
    if (busy === 1'b1) busy_cnt++;
    while (k < 40) begin
      @(posedge signal); #1;
      k++;
      if (start) start = 1'b0;
      if (done === 1'b1) break;
      if (busy === 1'b1) busy_cnt++;
      if (k == pulse_at) begin
        start = 1'b1;
        bin   = 14'd999;
      end
    end
    check({tag, "_latency"}, k, 15);
    check({tag, "_busy_cycles"}, busy_cnt, 14);
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        check({tag, "_sb_empty"}, 1, 0);
      end else begin
        e = q.pop_front();
        check({tag, "_bcd"}, bcd, e.bcd);
        check({tag, "_ovf"}, ovf, e.ovf);
        check({tag, "_blank"}, blank, e.blank);
      end
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge signal); #1;
      if (done === 1'b1) n++;
    end
    check({tag, "_no_done"}, n, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_bcd"}, bcd, 16'h0000);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_blank"}, blank, 4'b1110);
  endtask

  initial begin
    #12;
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge signal); #1;
    check_reset_vals("post_rst");

    start_conv(0);
    wait_done("zero", 0);

    start_conv(1523);
    wait_done("v1523", 0);
    @(posedge signal); #1;
    check("done_one_cycle", done, 0);
    check("hold_bcd", bcd, 16'h1523);

    start_conv(9999);
    wait_done("v9999", 0);
    start_conv(7);
    wait_done("v7", 0);

    start_conv(16383);
    wait_done("v16383", 0);

    start_conv(250);
    wait_done("v250", 5);
    expect_quiet("v250", 20);
    check("sb_drained", q.size(), 0);

    start_conv(4321);
    repeat (6) begin
      @(posedge signal); #1;
    end
    rst_n = 1'b0;
    #2;
    check_reset_vals("mid_rst");
    q.delete();
    repeat (2) @(posedge signal);
    #3;
    rst_n = 1'b1;
    expect_quiet("mid_rst", 20);
    check("mid_rst_hold_bcd", bcd, 16'h0000);

    start_conv(4321);
    wait_done("v4321", 0);

    start_conv(38);
    wait_done("v38", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
